// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_pkg
// Brief    : Shared types and constants for the execute-side branch resolver.
// Revision : 1.0 - initial release
// ============================================================================
package branch_pkg;

  localparam logic [3:0] OPC_BRANCH = 4'b1100;
  localparam int DEF_ADDR_W = 16;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic                  taken;
    logic [DEF_ADDR_W-1:0] target;
  } pred_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/branch_resolver_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolver_if
// Brief    : IF push, EX resolve, predictor training and fetch redirect bus.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_resolver_if
  import branch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              if_push;
  logic [ADDR_W-1:0] if_pc;
  logic              if_pred_taken;
  logic [ADDR_W-1:0] if_pred_target;

  logic              ex_valid;
  logic [ADDR_W-1:0] ex_pc;
  logic              ex_taken;
  logic [ADDR_W-1:0] ex_target;

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic [ADDR_W-1:0] upd_bta;
  logic              upd_taken;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush;

  logic              q_full;
  logic              q_empty;
  logic              q_ovf;

  modport master (
    output if_push, if_pc, if_pred_taken, if_pred_target,
    output ex_valid, ex_pc, ex_taken, ex_target,
    input  upd_valid, upd_pc, upd_bta, upd_taken,
    input  redirect_valid, redirect_pc, flush,
    input  q_full, q_empty, q_ovf
  );

  modport slave (
    input  if_push, if_pc, if_pred_taken, if_pred_target,
    input  ex_valid, ex_pc, ex_taken, ex_target,
    output upd_valid, upd_pc, upd_bta, upd_taken,
    output redirect_valid, redirect_pc, flush,
    output q_full, q_empty, q_ovf
  );

endinterface
`default_nettype wire

// File: rtl/pred_queue.sv
`default_nettype none
// ============================================================================
// Module   : pred_queue
// Brief    : In-order FIFO of pending branch predictions with flash clear.
// Revision : 1.0 - initial release
// ============================================================================
module pred_queue
  import branch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  pred_entry_t wr_entry,
  output pred_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  pred_entry_t      r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !clear) r_mem[r_wr_ptr] <= wr_entry;
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolver
// Brief    : Checks EX branch outcomes against queued IF predictions, trains
//            the predictor and redirects/flushes fetch on a mispredict.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolver
  import branch_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_resolver_if.slave   bus
);

  localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [FCNT_W-1:0] r_flush_cnt;
  logic [FCNT_W-1:0] w_flush_cnt_nxt;

  pred_entry_t w_head;
  pred_entry_t w_wr_entry;
  logic        w_full;
  logic        w_empty;

  logic w_mispredict;
  logic w_resolve;
  logic w_mis_evt;
  logic w_push;
  logic w_pop;
  logic w_clear;
  logic w_ovf_set;

  logic              r_upd_valid;
  logic [ADDR_W-1:0] r_upd_pc;
  logic [ADDR_W-1:0] r_upd_bta;
  logic              r_upd_taken;
  logic              r_redirect_valid;
  logic [ADDR_W-1:0] r_redirect_pc;
  logic              r_q_ovf;

  assign w_wr_entry.pc     = bus.if_pc;
  assign w_wr_entry.taken  = bus.if_pred_taken;
  assign w_wr_entry.target = bus.if_pred_target;

  pred_queue #(
    .DEPTH (DEPTH)
  ) u_pred_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .pop      (w_pop),
    .clear    (w_clear),
    .wr_entry (w_wr_entry),
    .head     (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  // With nothing queued, IF is assumed to have fetched the fall-through path.
  always_comb begin
    if (w_empty) begin
      w_mispredict = bus.ex_taken;
    end else begin
      w_mispredict = (w_head.pc != bus.ex_pc)
                   | (w_head.taken != bus.ex_taken)
                   | (bus.ex_taken & (w_head.target != bus.ex_target));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_resolve       = 1'b0;
    w_mis_evt       = 1'b0;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    w_clear         = 1'b0;
    case (r_state)
      RUN: begin
        w_resolve = bus.ex_valid;
        if (bus.ex_valid && w_mispredict) begin
          w_mis_evt       = 1'b1;
          w_clear         = 1'b1;
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = FCNT_W'(FLUSH_CYCLES - 1);
        end else begin
          w_pop  = bus.ex_valid;
          w_push = bus.if_push;
        end
      end
      FLUSH: begin
        // Squashed-instruction traffic is ignored until the count runs out.
        if (r_flush_cnt == '0) begin
          w_state_nxt = RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - FCNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  assign w_ovf_set = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd_valid      <= 1'b0;
      r_upd_pc         <= '0;
      r_upd_bta        <= '0;
      r_upd_taken      <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_q_ovf          <= 1'b0;
    end else begin
      r_upd_valid      <= w_resolve;
      r_redirect_valid <= w_mis_evt;
      r_q_ovf          <= r_q_ovf | w_ovf_set;
      if (w_resolve) begin
        r_upd_pc    <= bus.ex_pc;
        r_upd_bta   <= bus.ex_target;
        r_upd_taken <= bus.ex_taken;
      end
      if (w_mis_evt) begin
        r_redirect_pc <= bus.ex_taken ? bus.ex_target : (bus.ex_pc + ADDR_W'(1));
      end
    end
  end

  assign bus.upd_valid      = r_upd_valid;
  assign bus.upd_pc         = r_upd_pc;
  assign bus.upd_bta        = r_upd_bta;
  assign bus.upd_taken      = r_upd_taken;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.flush          = (r_state == FLUSH);
  assign bus.q_full         = w_full;
  assign bus.q_empty        = w_empty;
  assign bus.q_ovf          = r_q_ovf;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolver
// Brief    : Directed self-checking bench for branch_resolver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolver;

  logic clk;
  logic rst_n;
  int   ncmp;
  int   nerr;

  branch_resolver_if #(.ADDR_W(16)) bif ();

  branch_resolver #(
    .ADDR_W       (16),
    .DEPTH        (4),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bif.if_push = 1'b0; bif.if_pc = '0; bif.if_pred_taken = 1'b0; bif.if_pred_target = '0;
    bif.ex_valid = 1'b0; bif.ex_pc = '0; bif.ex_taken = 1'b0; bif.ex_target = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
    bif.if_push = 1'b1; bif.if_pc = pc; bif.if_pred_taken = tk; bif.if_pred_target = tgt;
  endtask

  task automatic resolve(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
    bif.ex_valid = 1'b1; bif.ex_pc = pc; bif.ex_taken = tk; bif.ex_target = tgt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    ncmp++; if (bif.upd_valid !== 1'b0) begin nerr++; $display("FAIL rst_upd_valid got=%b exp=0", bif.upd_valid); end
    ncmp++; if (bif.redirect_valid !== 1'b0 || bif.redirect_pc !== 16'h0) begin nerr++; $display("FAIL rst_redirect got=%b/%h exp=0/0000", bif.redirect_valid, bif.redirect_pc); end
    ncmp++; if (bif.flush !== 1'b0) begin nerr++; $display("FAIL rst_flush got=%b exp=0", bif.flush); end
    ncmp++; if (bif.q_empty !== 1'b1 || bif.q_full !== 1'b0 || bif.q_ovf !== 1'b0) begin nerr++; $display("FAIL rst_q got e/f/o=%b%b%b exp=100", bif.q_empty, bif.q_full, bif.q_ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_correct_not_taken();
    push(16'h0010, 1'b0, 16'h0000);
    step();
    ncmp++; if (bif.q_empty !== 1'b0) begin nerr++; $display("FAIL cnt_q_empty_after_push got=%b exp=0", bif.q_empty); end
    resolve(16'h0010, 1'b0, 16'h0000);
    step();
    ncmp++; if (bif.upd_valid !== 1'b1 || bif.upd_taken !== 1'b0 || bif.upd_pc !== 16'h0010) begin nerr++; $display("FAIL cnt_upd got v/t/pc=%b/%b/%h exp=1/0/0010", bif.upd_valid, bif.upd_taken, bif.upd_pc); end
    ncmp++; if (bif.redirect_valid !== 1'b0 || bif.flush !== 1'b0) begin nerr++; $display("FAIL cnt_no_redirect got rv/fl=%b/%b exp=0/0", bif.redirect_valid, bif.flush); end
    ncmp++; if (bif.q_empty !== 1'b1) begin nerr++; $display("FAIL cnt_q_empty got=%b exp=1", bif.q_empty); end
    step();
    ncmp++; if (bif.upd_valid !== 1'b0) begin nerr++; $display("FAIL cnt_upd_one_cycle got=%b exp=0", bif.upd_valid); end
  endtask

  task automatic test_target_mismatch();
    push(16'h0020, 1'b1, 16'h0040);
    step();
    resolve(16'h0020, 1'b1, 16'h0044);
    step();
    ncmp++; if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 16'h0044) begin nerr++; $display("FAIL tgt_redirect got v/pc=%b/%h exp=1/0044", bif.redirect_valid, bif.redirect_pc); end
    ncmp++; if (bif.flush !== 1'b1 || bif.q_empty !== 1'b1) begin nerr++; $display("FAIL tgt_flush1 got fl/e=%b/%b exp=1/1", bif.flush, bif.q_empty); end
    ncmp++; if (bif.upd_valid !== 1'b1 || bif.upd_bta !== 16'h0044 || bif.upd_taken !== 1'b1) begin nerr++; $display("FAIL tgt_upd got v/bta/t=%b/%h/%b exp=1/0044/1", bif.upd_valid, bif.upd_bta, bif.upd_taken); end
    push(16'h0099, 1'b0, 16'h0000);
    resolve(16'h0077, 1'b1, 16'h0088);
    step();
    ncmp++; if (bif.flush !== 1'b1 || bif.redirect_valid !== 1'b0 || bif.upd_valid !== 1'b0) begin nerr++; $display("FAIL tgt_flush2 got fl/rv/uv=%b/%b/%b exp=1/0/0", bif.flush, bif.redirect_valid, bif.upd_valid); end
    step();
    ncmp++; if (bif.flush !== 1'b0 || bif.q_empty !== 1'b1 || bif.redirect_valid !== 1'b0) begin nerr++; $display("FAIL tgt_flush_end got fl/e/rv=%b/%b/%b exp=0/1/0", bif.flush, bif.q_empty, bif.redirect_valid); end
  endtask

  task automatic test_wrap();
    push(16'hFFFF, 1'b1, 16'h0100);
    step();
    resolve(16'hFFFF, 1'b0, 16'h0100);
    step();
    ncmp++; if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 16'h0000) begin nerr++; $display("FAIL wrap_redirect got v/pc=%b/%h exp=1/0000", bif.redirect_valid, bif.redirect_pc); end
    step();
    ncmp++; if (bif.flush !== 1'b1) begin nerr++; $display("FAIL wrap_flush2 got=%b exp=1", bif.flush); end
    step();
    ncmp++; if (bif.flush !== 1'b0) begin nerr++; $display("FAIL wrap_flush_end got=%b exp=0", bif.flush); end
    // first cycle after flush drops: resolve must be accepted
    resolve(16'h0040, 1'b0, 16'h0000);
    step();
    ncmp++; if (bif.upd_valid !== 1'b1 || bif.upd_pc !== 16'h0040 || bif.redirect_valid !== 1'b0) begin nerr++; $display("FAIL wrap_post_flush got uv/pc/rv=%b/%h/%b exp=1/0040/0", bif.upd_valid, bif.upd_pc, bif.redirect_valid); end
  endtask

  task automatic test_full_ovf();
    for (int i = 0; i < 4; i++) begin
      push(16'h0100 + 16'(i), 1'b0, 16'h0000);
      step();
    end
    ncmp++; if (bif.q_full !== 1'b1 || bif.q_ovf !== 1'b0) begin nerr++; $display("FAIL full_4 got f/o=%b/%b exp=1/0", bif.q_full, bif.q_ovf); end
    push(16'h01FF, 1'b1, 16'h0BAD);
    step();
    ncmp++; if (bif.q_full !== 1'b1 || bif.q_ovf !== 1'b1) begin nerr++; $display("FAIL full_drop got f/o=%b/%b exp=1/1", bif.q_full, bif.q_ovf); end
    push(16'h0104, 1'b0, 16'h0000);
    resolve(16'h0100, 1'b0, 16'h0000);
    step();
    ncmp++; if (bif.q_full !== 1'b1 || bif.redirect_valid !== 1'b0 || bif.upd_valid !== 1'b1) begin nerr++; $display("FAIL full_push_pop got f/rv/uv=%b/%b/%b exp=1/0/1", bif.q_full, bif.redirect_valid, bif.upd_valid); end
    for (int i = 1; i <= 4; i++) begin
      resolve(16'h0100 + 16'(i), 1'b0, 16'h0000);
      step();
      ncmp++; if (bif.redirect_valid !== 1'b0 || bif.q_full !== 1'b0) begin nerr++; $display("FAIL drain_%0d got rv/f=%b/%b exp=0/0", i, bif.redirect_valid, bif.q_full); end
    end
    ncmp++; if (bif.q_empty !== 1'b1 || bif.q_ovf !== 1'b1) begin nerr++; $display("FAIL drain_end got e/o=%b/%b exp=1/1", bif.q_empty, bif.q_ovf); end
  endtask

  task automatic test_empty_resolve();
    resolve(16'h0031, 1'b0, 16'h0000);
    step();
    ncmp++; if (bif.redirect_valid !== 1'b0 || bif.upd_valid !== 1'b1) begin nerr++; $display("FAIL empty_nt got rv/uv=%b/%b exp=0/1", bif.redirect_valid, bif.upd_valid); end
    resolve(16'h0030, 1'b1, 16'h0050);
    step();
    ncmp++; if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 16'h0050 || bif.flush !== 1'b1) begin nerr++; $display("FAIL empty_tk_redirect got rv/pc/fl=%b/%h/%b exp=1/0050/1", bif.redirect_valid, bif.redirect_pc, bif.flush); end
    ncmp++; if (bif.upd_valid !== 1'b1 || bif.upd_pc !== 16'h0030 || bif.upd_bta !== 16'h0050 || bif.upd_taken !== 1'b1) begin nerr++; $display("FAIL empty_tk_upd got v/pc/bta/t=%b/%h/%h/%b exp=1/0030/0050/1", bif.upd_valid, bif.upd_pc, bif.upd_bta, bif.upd_taken); end
    repeat (2) step();
  endtask

  task automatic test_reset_mid_flush();
    push(16'h0060, 1'b0, 16'h0000);
    step();
    resolve(16'h0061, 1'b0, 16'h0000);
    step();
    ncmp++; if (bif.flush !== 1'b1) begin nerr++; $display("FAIL rmf_flush_before got=%b exp=1", bif.flush); end
    #2;
    rst_n = 1'b0;
    #1;
    ncmp++; if (bif.flush !== 1'b0 || bif.q_empty !== 1'b1 || bif.q_ovf !== 1'b0 || bif.redirect_valid !== 1'b0) begin nerr++; $display("FAIL rmf_async got fl/e/o/rv=%b/%b/%b/%b exp=0/1/0/0", bif.flush, bif.q_empty, bif.q_ovf, bif.redirect_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    push(16'h0070, 1'b1, 16'h0080);
    step();
    resolve(16'h0070, 1'b1, 16'h0080);
    step();
    ncmp++; if (bif.upd_valid !== 1'b1 || bif.redirect_valid !== 1'b0 || bif.flush !== 1'b0 || bif.q_empty !== 1'b1) begin nerr++; $display("FAIL rmf_run got uv/rv/fl/e=%b/%b/%b/%b exp=1/0/0/1", bif.upd_valid, bif.redirect_valid, bif.flush, bif.q_empty); end
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    rst_n = 1'b0;
    idle();
    test_reset();
    test_correct_not_taken();
    test_target_mismatch();
    test_wrap();
    test_full_ovf();
    test_empty_resolve();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_resolver.md
# branch_resolver

Execute-side counterpart of the fetch-stage branch predictor. It holds every prediction made in IF in a small in-order queue and compares the oldest entry with the real outcome when EX resolves a branch (opcode 4'b1100). It always drives the predictor's training write port (PC, BTA, taken). On a misprediction it also redirects fetch and drives a multi-cycle pipeline flush.

## Interface
- ADDR_W, 16: PC/target width (word-addressed PC).
- DEPTH, 4: prediction queue entries (power of two, ≥2).
- FLUSH_CYCLES, 2: cycles `flush` stays high after a mispredict (≥1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- if_push  in  1  IF fetched a branch this cycle; record its prediction.
- if_pc  in  ADDR_W  PC of that branch.
- if_pred_taken  in  1  predictor's taken bit for it.
- if_pred_target  in  ADDR_W  predictor's target for it (don't-care if not taken).
- ex_valid  in  1  EX resolves a branch this cycle.
- ex_pc  in  ADDR_W  PC of resolved branch.
- ex_taken  in  1  actual outcome.
- ex_target  in  ADDR_W  actual branch target address.
- upd_valid  out  1  one-cycle training strobe to predictor.
- upd_pc, upd_bta  out  ADDR_W  training PC / branch target.
- upd_taken  out  1  training outcome.
- redirect_valid  out  1  one-cycle fetch redirect strobe.
- redirect_pc  out  ADDR_W  corrected fetch PC.
- flush  out  1  kill younger IF/ID/EX instructions.
- q_full, q_empty  out  1  queue status.
- q_ovf  out  1  sticky: a push was dropped because the queue was full.

## Operation
- FSM states: RUN, FLUSH. Reset enters RUN with the queue empty.
- **RUN, ex_valid=1:**
  - If the queue is non-empty, compare against the head. Mispredict = (head.pc≠ex_pc) | (head.taken≠ex_taken) | (ex_taken & head.target≠ex_target).
  - If the queue is empty, the prediction is treated as not-taken. Mispredict = ex_taken.
  - Training happens on every resolve: upd_pc=ex_pc, upd_bta=ex_target, upd_taken=ex_taken.
  - Correct prediction: pop the head; no redirect.
  - Mispredict: clear the whole queue and go to FLUSH. Drive redirect_pc = ex_taken ? ex_target : ex_pc+1. The +1 is modulo 2^ADDR_W, so FFFF+1=0000.
- **RUN, if_push=1:**
  - Push {if_pc, if_pred_taken, if_pred_target}.
  - If the queue is full and there is no simultaneous pop, drop the push and set q_ovf.
  - A push and a correct-prediction pop in the same cycle both take effect. The count is unchanged, and a push to a full queue succeeds in this case.
  - A push in the same cycle as a mispredict is discarded.
- **FLUSH:**
  - if_push and ex_valid are ignored; they come from squashed instructions.
  - Return to RUN after FLUSH_CYCLES cycles.
- An active rst_n immediately clears all state, including an in-progress FLUSH.

## Timing
- Reset values: every output 0 except q_empty=1. q_ovf is cleared only by reset.
- upd_* and redirect_* are registered. They appear the cycle after the ex_valid edge and last one cycle.
- flush rises in the same cycle as redirect_valid. It stays high for exactly FLUSH_CYCLES consecutive cycles.
- A resolve accepted in the cycle right after flush drops is legal.
- q_full and q_empty reflect the registered count; they update one cycle after push/pop.
- Throughput: one resolve and one push per cycle in RUN.

## Structure
- Shared package `branch_pkg` holds:
  - OPC_BRANCH = 4'b1100;
  - ADDR_W default;
  - typedef `pred_entry_t` {pc, taken, target};
  - state enum {RUN, FLUSH}.
- Sub-module `pred_queue`: a synchronous FIFO of pred_entry_t.
  - Inputs: push, pop, clear.
  - Outputs: head, full, empty.
  - Wrap-around read/write pointers plus a count.
- The top level contains the compare logic, the FSM and the flush counter.

## Test plan
- Correct not-taken: push {0x0010,0,x}, resolve {0x0010,0,x} → next cycle upd_valid=1, upd_taken=0, no flush, q_empty=1.
- Target mismatch: push {0x0020,1,0x0040}, resolve {0x0020,1,0x0044} → redirect_pc=0x0044, flush high for 2 cycles, queue cleared. A push during FLUSH is ignored.
- Fall-through wrap: push {0xFFFF,1,0x0100}, resolve not-taken → redirect_pc=0x0000.
- Full/overflow: 4 pushes give q_full=1. A 5th lone push is dropped and sets q_ovf=1. Push and correct pop in the same cycle keep count=4 with no ovf.
- Empty-queue resolve {0x0030,1,0x0050} → mispredict, redirect_pc=0x0050. The upd_* values are still issued.
- Assert rst_n=0 mid-FLUSH → flush=0 and q_empty=1 immediately. After release the block is in RUN.
